// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch/execute sequencer owning the PC.
// Fetches over req/ack, strobes alu_en once, then resolves the next PC from branch_reg.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        is_b_instr,
    input  logic        is_j_instr,
    input  logic        is_jr_instr,
    input  logic [31:0] imm,
    input  logic [31:0] src1,
    input  logic        branch_reg,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr_reg,
    output logic        alu_en,
    output logic [31:0] link_addr,
    output logic        retire,
    output logic        misalign_exc
);
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, RESOLVE = 2'd3;
    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, link_q, link_d, target;
    logic        alu_en_q, retire_q, misalign_q;
    logic        unused_flags;
    // B and JAL share the pc+imm path, so their decode flags do not steer anything
    assign unused_flags = is_b_instr ^ is_j_instr;
    assign target = !branch_reg ? pc_q + 32'd4
                  : is_jr_instr ? (src1 + imm) & ~32'h1
                  : pc_q + imm;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        link_d  = link_q;
        case (state_q)
            IDLE:    state_d = run ? FETCH : IDLE;
            FETCH:   if (imem_ack) begin
                         instr_d = imem_rdata;
                         link_d  = pc_q + 32'd4;
                         state_d = EXEC;
                     end
            EXEC:    state_d = RESOLVE;
            default: begin
                         pc_d    = target[1] ? TRAP_PC : target;
                         state_d = run ? FETCH : IDLE;
                     end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            link_q     <= '0;
            alu_en_q   <= 1'b0;
            retire_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            link_q     <= link_d;
            alu_en_q   <= state_q == FETCH && imem_ack;
            retire_q   <= state_q == EXEC;
            misalign_q <= state_q == RESOLVE && target[1];
        end
    end
    assign pc           = pc_q;
    assign imem_req     = state_q == FETCH;
    assign imem_addr    = pc_q;
    assign instr_reg    = instr_q;
    assign link_addr    = link_q;
    assign alu_en       = alu_en_q;
    assign retire       = retire_q;
    assign misalign_exc = misalign_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized scoreboard bench for pc_sequencer.
// The driver pushes expected exec/resolve results; a monitor pops them on alu_en and after retire.
module tb_pc_sequencer;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP   = 32'h0000_0100;
    logic        clk = 0, rst = 1, run = 0, imem_ack = 0;
    logic        is_b = 0, is_j = 0, is_jr = 0, branch_reg = 0;
    logic [31:0] imem_rdata = 0, imm = 0, src1 = 0;
    logic [31:0] pc, imem_addr, instr_reg, link_addr;
    logic        imem_req, alu_en, retire, misalign_exc;
    int          checks = 0, errors = 0;
    logic [95:0] exp_exec[$];
    logic [32:0] exp_ret[$];
    logic [31:0] mpc = RST_PC;
    logic        pend = 0, pa = 0, pr = 0, pm = 0, preq = 0;
    logic [31:0] paddr = 0;

    pc_sequencer #(.RESET_PC(RST_PC), .TRAP_PC(TRAP)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .is_b_instr(is_b), .is_j_instr(is_j), .is_jr_instr(is_jr), .imm(imm), .src1(src1),
        .branch_reg(branch_reg), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .instr_reg(instr_reg), .alu_en(alu_en), .link_addr(link_addr), .retire(retire),
        .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: exec results on alu_en, next pc / trap in the cycle after retire
    initial forever begin
        @(negedge clk);
        if (rst) pend = 0;
        else begin
            if (pend) begin
                if (exp_ret.size() == 0) chk("ret_queue_empty", 32'd0, 32'd1);
                else begin
                    logic [32:0] e;
                    e = exp_ret.pop_front();
                    chk("next_pc", pc, e[31:0]);
                    chk("misalign", {31'd0, misalign_exc}, {31'd0, e[32]});
                end
            end else if (misalign_exc) chk("spurious_misalign", {31'd0, misalign_exc}, 32'd0);
            pend = retire;
            if (alu_en) begin
                if (exp_exec.size() == 0) chk("unexpected_alu_en", {31'd0, alu_en}, 32'd0);
                else begin
                    logic [95:0] x;
                    x = exp_exec.pop_front();
                    chk("exec_pc", pc, x[95:64]);
                    chk("instr_reg", instr_reg, x[63:32]);
                    chk("link_addr", link_addr, x[31:0]);
                end
            end
            if (imem_req && preq) chk("addr_stable", imem_addr, paddr);
            if (alu_en && pa) chk("alu_en_twice", {31'd0, alu_en}, 32'd0);
            if (retire && pr) chk("retire_twice", {31'd0, retire}, 32'd0);
            if (misalign_exc && pm) chk("misalign_twice", {31'd0, misalign_exc}, 32'd0);
        end
        preq = imem_req; paddr = imem_addr; pa = alu_en; pr = retire; pm = misalign_exc;
    end

    // kind: 0 = B, 1 = JAL, 2 = JALR
    task automatic do_instr(int dly, int kind, logic [31:0] im, logic [31:0] s1, logic tk, logic run_after);
        logic [31:0] t;
        int n;
        run = 1;
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            errors++;
            $display("FAIL fetch_timeout got imem_req=0 expected 1 at %0t", $time);
            return;
        end
        repeat (dly) @(negedge clk);
        imem_rdata = $urandom;
        imem_ack = 1;
        exp_exec.push_back({mpc, imem_rdata, mpc + 32'd4});
        is_b = kind == 0; is_j = kind == 1; is_jr = kind == 2; imm = im; src1 = s1;
        t = !tk ? mpc + 32'd4 : kind == 2 ? (s1 + im) & ~32'h1 : mpc + im;
        mpc = t[1] ? TRAP : t;
        exp_ret.push_back({t[1], mpc});
        @(negedge clk);
        imem_ack = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        branch_reg = tk;
        run = run_after;
        @(negedge clk);
        imem_ack = 0;
        @(negedge clk);
        branch_reg = 1'($urandom_range(0, 1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, RST_PC);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_exc}, 32'd0);
        chk("rst_instr", instr_reg, 32'd0);
        chk("rst_link", link_addr, 32'd0);
        rst = 0;
        for (int i = 0; i < 8; i++) do_instr(i % 2, 0, $urandom, 32'd0, 1'b0, 1'b1);
        do_instr(1, 0, 32'hFFFF_FFF0, 32'd0, 1'b1, 1'b1);
        do_instr(0, 2, 32'h4, 32'h1003, 1'b1, 1'b1);
        do_instr(0, 2, 32'h4, 32'h1001, 1'b1, 1'b1);
        do_instr(5, 1, 32'h40, 32'd0, 1'b1, 1'b1);
        do_instr(0, 0, 32'h8, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1;
            imem_rdata = $urandom;
            @(negedge clk);
            chk("idle_req", {31'd0, imem_req}, 32'd0);
            chk("idle_alu_en", {31'd0, alu_en}, 32'd0);
            chk("idle_pc", pc, mpc);
        end
        imem_ack = 0;
        do_instr(0, 0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int n = 0; n < 50 && !imem_req; n++) @(negedge clk);
        chk("prerst_req", {31'd0, imem_req}, 32'd1);
        #2 rst = 1;
        #1;
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_instr", instr_reg, 32'd0);
        chk("midrst_link", link_addr, 32'd0);
        chk("midrst_strobes", {29'd0, alu_en, retire, misalign_exc}, 32'd0);
        run = 0;
        imem_ack = 1;
        imem_rdata = $urandom;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        chk("postrst_req", {31'd0, imem_req}, 32'd0);
        chk("postrst_pc", pc, RST_PC);
        chk("postrst_instr", instr_reg, 32'd0);
        chk("postrst_alu_en", {31'd0, alu_en}, 32'd0);
        imem_ack = 0;
        mpc = RST_PC;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] im;
            im = $urandom & ~32'h1;
            if ($urandom_range(0, 3) == 0) im = {{24{im[7]}}, im[7:0]};
            do_instr($urandom_range(0, 3), $urandom_range(0, 2), im, $urandom,
                     1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
        end
        repeat (3) @(negedge clk);
        chk("exec_queue_drained", exp_exec.size(), 32'd0);
        chk("ret_queue_drained", exp_ret.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
